tone_env_gen: RTL and testbench

Downstream audio stage that consumes the 3-bit note index and valid flag from the switch-to-note coder and produces a signed PCM sample stream. It generates a tone with a phase accumulator at a fixed sample rate. It applies a linear attack/release envelope driven by the note-valid flag. Samples are offered to the audio codec interface over a valid/ready handshake.

---
 rtl/tone_env_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_tone_env_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tone_env_gen.sv
// tone_env_gen: tone generator with linear attack/release envelope.
// A phase accumulator advances once per sample tick, a four-state envelope
// follows the held-note flag, and each tick offers one signed PCM sample to
// the codec over a valid/ready handshake.
// Optional build macro: TONE_ENV_GEN_TRIANGLE_EN selects a triangle waveform
// through an extra registered multiply stage; by default a square is produced.
module tone_env_gen #(
  parameter int SAMPLE_DIV = 1042,
  parameter int ENV_STEP   = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  num_i,
  input  logic        num_val_i,
  output logic [15:0] sample_o,
  output logic        sample_val_o,
  input  logic        sample_ready_i,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int              CW      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SAMPLE_DIV - 1);
  localparam logic [16:0]     STEP    = 17'(ENV_STEP);
  localparam logic [14:0]     ENV_MAX = 15'h7fff;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Phase increments for C4..C5 at a 48 kHz sample rate.
  function automatic logic [15:0] note_inc(input logic [2:0] idx);
    case (idx)
      3'd0:    note_inc = 16'd357;
      3'd1:    note_inc = 16'd401;
      3'd2:    note_inc = 16'd450;
      3'd3:    note_inc = 16'd477;
      3'd4:    note_inc = 16'd535;
      3'd5:    note_inc = 16'd601;
      3'd6:    note_inc = 16'd674;
      default: note_inc = 16'd714;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    num_r1_q, num_r1_d;
  logic          val_r1_q, val_r1_d;
  logic [15:0]   inc_q, inc_d;
  logic [15:0]   phase_q, phase_d;
  logic [14:0]   env_q, env_d;
  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [15:0]   sample_q, sample_d;
  logic          sample_val_q, sample_val_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic [16:0]   env_up;
  logic [14:0]   env_up_sat;
  logic [14:0]   env_dn_sat;
  logic [15:0]   wave;
  logic          load_en;
  logic [15:0]   load_val;

`ifdef TONE_ENV_GEN_TRIANGLE_EN
  logic [15:0]        prod_q, prod_d;
  logic               load_pend_q, load_pend_d;
  logic [14:0]        tri_v;
  logic signed [16:0] tri_s;
  logic signed [33:0] tri_prod;
`endif

  // Tick counter, input stage, envelope FSM and phase accumulator next state.
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    num_r1_d = num_i;
    val_r1_d = num_val_i;

    inc_d = inc_q;
    if (tick && val_r1_q) begin
      inc_d = note_inc(num_r1_q);
    end

    env_up     = {2'b00, env_q} + STEP;
    env_up_sat = (env_up >= {2'b00, ENV_MAX}) ? ENV_MAX : env_up[14:0];
    env_dn_sat = ({2'b00, env_q} <= STEP) ? 15'd0 : env_q - STEP[14:0];

    state_d = state_q;
    env_d   = env_q;
    phase_d = phase_q;
    if (tick) begin
      if (state_q != ST_IDLE) begin
        phase_d = phase_q + inc_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (val_r1_q) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          // Releasing the note wins over reaching full scale.
          if (!val_r1_q) begin
            state_d = ST_RELEASE;
          end else begin
            env_d = env_up_sat;
            if (env_up_sat == ENV_MAX) state_d = ST_SUSTAIN;
          end
        end
        ST_SUSTAIN: begin
          if (!val_r1_q) state_d = ST_RELEASE;
        end
        default: begin
          // Retrigger restarts the attack from the current level.
          if (val_r1_q) begin
            state_d = ST_ATTACK;
          end else begin
            env_d = env_dn_sat;
            if (env_dn_sat == 15'd0) begin
              state_d = ST_IDLE;
              phase_d = '0;
            end
          end
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);

    // Square wave built from the post-tick envelope and phase.
    if (state_d == ST_IDLE) begin
      wave = '0;
    end else if (phase_d[15]) begin
      wave = 16'd0 - {1'b0, env_d};
    end else begin
      wave = {1'b0, env_d};
    end
  end

`ifdef TONE_ENV_GEN_TRIANGLE_EN
  // Triangle shaping and envelope multiply, captured one cycle before output load.
  always_comb begin
    tri_v       = phase_d[15] ? ~phase_d[14:0] : phase_d[14:0];
    tri_s       = $signed({1'b0, tri_v, 1'b0}) - 17'sd32767;
    tri_prod    = tri_s * $signed({2'b00, env_d});
    prod_d      = (state_d == ST_IDLE) ? 16'd0 : tri_prod[30:15];
    load_pend_d = tick;
    load_en     = load_pend_q;
    load_val    = prod_q;
  end
`else
  // Square output loads directly on the tick.
  always_comb begin
    load_en  = tick;
    load_val = wave;
  end
`endif

  // Output register with valid/ready handshake and sticky overrun.
  always_comb begin
    sample_d     = sample_q;
    sample_val_d = sample_val_q;
    overrun_d    = overrun_q;
    if (load_en) begin
      if (sample_val_q && !sample_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        sample_d     = load_val;
        sample_val_d = 1'b1;
      end
    end else if (sample_val_q && sample_ready_i) begin
      sample_val_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      num_r1_q     <= '0;
      val_r1_q     <= 1'b0;
      inc_q        <= '0;
      phase_q      <= '0;
      env_q        <= '0;
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      sample_q     <= '0;
      sample_val_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      num_r1_q     <= num_r1_d;
      val_r1_q     <= val_r1_d;
      inc_q        <= inc_d;
      phase_q      <= phase_d;
      env_q        <= env_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      sample_q     <= sample_d;
      sample_val_q <= sample_val_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef TONE_ENV_GEN_TRIANGLE_EN
  // Multiply pipeline stage.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prod_q      <= '0;
      load_pend_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      load_pend_q <= load_pend_d;
    end
  end
`endif

  assign sample_o     = sample_q;
  assign sample_val_o = sample_val_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_tone_env_gen.sv
// Directed bench for tone_env_gen (square build) with SAMPLE_DIV = 4 and
// ENV_STEP = 8192, so sample ticks land on every fourth edge after reset.
module tb_tone_env_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  num_i;
  logic        num_val_i;
  logic [15:0] sample_o;
  logic        sample_val_o;
  logic        sample_ready_i;
  logic        overrun_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  tone_env_gen #(.SAMPLE_DIV(4), .ENV_STEP(8192)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .num_i          (num_i),
    .num_val_i      (num_val_i),
    .sample_o       (sample_o),
    .sample_val_o   (sample_val_o),
    .sample_ready_i (sample_ready_i),
    .overrun_o      (overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts one comparison and reports it.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_smp(input string tag, input logic [15:0] exp);
    chk({tag, ".val"}, {31'd0, sample_val_o}, 32'd1);
    chk({tag, ".smp"}, {16'd0, sample_o}, {16'd0, exp});
  endtask

  initial begin
    rst_n_i        = 1'b0;
    num_i          = 3'd5;
    num_val_i      = 1'b1;
    sample_ready_i = 1'b1;

    // Reset held 5 cycles with a note asserted: outputs stay zero.
    for (int i = 0; i < 5; i++) begin
      adv(1);
      chk("rst.smp",  {16'd0, sample_o}, 32'd0);
      chk("rst.val",  {31'd0, sample_val_o}, 32'd0);
      chk("rst.ovr",  {31'd0, overrun_o}, 32'd0);
      chk("rst.busy", {31'd0, busy_o}, 32'd0);
    end
    rst_n_i = 1'b1;

    // First tick is the fourth cycle after release.
    for (int i = 1; i <= 3; i++) begin
      adv(1);
      chk("pre_tick.val", {31'd0, sample_val_o}, 32'd0);
    end
    adv(1);                                   // E4: IDLE -> ATTACK
    chk_smp("e4", 16'd0);
    chk("e4.busy", {31'd0, busy_o}, 32'd1);

    // Attack: 8192, 16384, 24576, 32767; phase advances by 601.
    adv(4); chk_smp("att1", 16'd8192);  chk("att1.ph", {16'd0, dut.phase_q}, 32'd601);
    adv(4); chk_smp("att2", 16'd16384);
    adv(4); chk_smp("att3", 16'd24576); chk("att3.ph", {16'd0, dut.phase_q}, 32'd1803);
    adv(4); chk_smp("att4", 16'd32767);
    adv(4); chk_smp("sus5", 16'd32767);

    // Sustain until phase[15] sets: 601*54 = 32454, 601*55 = 33055.
    for (int k = 6; k <= 54; k++) adv(4);
    chk_smp("sus54", 16'd32767);
    adv(4);
    chk_smp("sus55", 16'h8001);
    chk("sus55.ph", {16'd0, dut.phase_q}, 32'd33055);
    num_val_i = 1'b0;

    // Release (phase stays in negative half): -32767, -24575, -16383, -8191, 0.
    adv(4); chk_smp("rel0", 16'h8001);
    adv(4); chk_smp("rel1", 16'hA001);
    adv(4); chk_smp("rel2", 16'hC001);
    adv(4); chk_smp("rel3", 16'hE001);
    adv(4); chk_smp("rel4", 16'd0);
    chk("idle.busy", {31'd0, busy_o}, 32'd0);
    chk("idle.ph",   {16'd0, dut.phase_q}, 32'd0);

    // New note C4 up to sustain.
    num_i     = 3'd0;
    num_val_i = 1'b1;
    adv(4); chk_smp("n2.start", 16'd0); chk("n2.busy", {31'd0, busy_o}, 32'd1);
    adv(4); chk_smp("n2.a1", 16'd8192);
    adv(4); chk_smp("n2.a2", 16'd16384);
    adv(4); chk_smp("n2.a3", 16'd24576);
    adv(4); chk_smp("n2.a4", 16'd32767);
    chk("n2.ph", {16'd0, dut.phase_q}, 32'd1428);

    // Note change 0 -> 7: one more 357 step, then 714 steps.
    num_i = 3'd7;
    adv(4); chk("nc1.ph", {16'd0, dut.phase_q}, 32'd1785);
    adv(4); chk("nc2.ph", {16'd0, dut.phase_q}, 32'd2499); chk_smp("nc2", 16'd32767);

    // Release then retrigger at 16383.
    num_val_i = 1'b0;
    adv(4); chk_smp("rt.r0", 16'd32767);
    adv(4); chk_smp("rt.r1", 16'd24575);
    adv(4); chk_smp("rt.r2", 16'd16383);
    num_val_i = 1'b1;
    adv(4); chk_smp("rt.hold", 16'd16383); chk("rt.ph", {16'd0, dut.phase_q}, 32'd5355);
    adv(4); chk_smp("rt.a1", 16'd24575);

    // Backpressure across two ticks.
    sample_ready_i = 1'b0;
    adv(2); chk_smp("bp.mid", 16'd24575); chk("bp.ovr0", {31'd0, overrun_o}, 32'd0);
    adv(2); chk_smp("bp.t1", 16'd24575);  chk("bp.ovr1", {31'd0, overrun_o}, 32'd1);
    adv(4); chk_smp("bp.t2", 16'd24575);
    sample_ready_i = 1'b1;
    adv(1); chk("bp.xfer.val", {31'd0, sample_val_o}, 32'd0);
    chk("bp.sticky", {31'd0, overrun_o}, 32'd1);
    adv(3); chk_smp("st.t1", 16'd32767);
    adv(1); chk("st.gap.val", {31'd0, sample_val_o}, 32'd0);
    adv(3); chk_smp("st.t2", 16'd32767);

    // Reset mid-operation clears everything on the next edge.
    rst_n_i = 1'b0;
    adv(1);
    chk("mrst.smp",  {16'd0, sample_o}, 32'd0);
    chk("mrst.val",  {31'd0, sample_val_o}, 32'd0);
    chk("mrst.ovr",  {31'd0, overrun_o}, 32'd0);
    chk("mrst.busy", {31'd0, busy_o}, 32'd0);
    chk("mrst.ph",   {16'd0, dut.phase_q}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
